// File: rtl/usb_reset_sequencer.sv
// rtl/usb_reset_sequencer.sv - synchronised, glitch-filtered reset request to timed PHY/link/protocol release
// Optional watchdog on a stuck-low request is built when USB_RST_WDOG_EN is defined.
module usb_reset_sequencer #(
  parameter int MIN_PULSE = 4,
  parameter int STAGE_DLY = 8,
  parameter int CNT_W     = 8,
  parameter int WDOG_CYC  = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             reset_n,
  output logic             phy_rst_o,
  output logic             link_rst_o,
  output logic             prot_rst_o,
  output logic             rst_done_o,
  output logic [CNT_W-1:0] rst_cnt_o,
  output logic             wdog_err_o
);

  localparam int FLT_W = $clog2(MIN_PULSE + 1);
  localparam int TMR_W = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;

  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(MIN_PULSE);
  localparam logic [FLT_W-1:0] FLT_PRE = FLT_W'(MIN_PULSE - 1);
  localparam logic [TMR_W-1:0] TMR_RLD = TMR_W'(STAGE_DLY - 1);

  localparam logic [2:0] HOLD     = 3'd0;
  localparam logic [2:0] REL_PHY  = 3'd1;
  localparam logic [2:0] REL_LINK = 3'd2;
  localparam logic [2:0] REL_PROT = 3'd3;
  localparam logic [2:0] RUN      = 3'd4;

  logic             sync_q1;
  logic             req_n_s;
  logic [FLT_W-1:0] flt_cnt;
  logic             acc_p;
  logic             acc_q;
  logic [2:0]       state;
  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q1 <= 1'b1;
      req_n_s <= 1'b1;
    end else begin
      sync_q1 <= reset_n;
      req_n_s <= sync_q1;
    end
  end

  // acc_p marks the cycle flt_cnt reaches MIN_PULSE; acc_q is the registered event the FSM acts on
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flt_cnt <= '0;
      acc_p   <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      acc_p <= !req_n_s && (flt_cnt == FLT_PRE);
      acc_q <= acc_p;
      if (req_n_s) begin
        flt_cnt <= '0;
      end else if (flt_cnt != FLT_MAX) begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // An accepted request overrides any release step, so the two never land on the same cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= HOLD;
      timer      <= '0;
      phy_rst_o  <= 1'b1;
      link_rst_o <= 1'b1;
      prot_rst_o <= 1'b1;
      rst_done_o <= 1'b0;
      rst_cnt_o  <= '0;
    end else begin
      rst_done_o <= 1'b0;
      if (acc_q) begin
        state      <= HOLD;
        timer      <= '0;
        phy_rst_o  <= 1'b1;
        link_rst_o <= 1'b1;
        prot_rst_o <= 1'b1;
        if (!(&rst_cnt_o)) begin
          rst_cnt_o <= rst_cnt_o + 1'b1;
        end
      end else begin
        case (state)
          HOLD: begin
            if (req_n_s && (flt_cnt == '0)) begin
              state <= REL_PHY;
              timer <= TMR_RLD;
            end
          end
          REL_PHY: begin
            if (timer == '0) begin
              phy_rst_o <= 1'b0;
              state     <= REL_LINK;
              timer     <= TMR_RLD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          REL_LINK: begin
            if (timer == '0) begin
              link_rst_o <= 1'b0;
              state      <= REL_PROT;
              timer      <= TMR_RLD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          REL_PROT: begin
            if (timer == '0) begin
              prot_rst_o <= 1'b0;
              rst_done_o <= 1'b1;
              state      <= RUN;
              timer      <= TMR_RLD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          RUN: begin
          end
          default: begin
            state      <= HOLD;
            timer      <= '0;
            phy_rst_o  <= 1'b1;
            link_rst_o <= 1'b1;
            prot_rst_o <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef USB_RST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYC);

  logic [WD_W-1:0] wdog_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wdog_cnt   <= '0;
      wdog_err_o <= 1'b0;
    end else begin
      if (req_n_s) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt != WD_MAX) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_cnt == WD_MAX) begin
        wdog_err_o <= 1'b1;
      end
    end
  end
`else
  // Watchdog not built; the term keeps WDOG_CYC part of the interface in this build
  assign wdog_err_o = 1'b0 & (WDOG_CYC > 0);
`endif

endmodule
